// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: state encoding and sizing helpers shared by the serial subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter width for n digit steps; never narrower than one bit.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/serial_sub_if.sv
// serial_sub_if: start/done request and result bundle of the serial subtractor.
// Carries ovf only when SERIAL_SUB_OVF_EN is defined.
interface serial_sub_if #(parameter int WIDTH = 16);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             b_out;
    logic             zero;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;

    modport master (output start, a, b, b_in, input busy, done, d, b_out, zero, ovf);
    modport slave  (input start, a, b, b_in, output busy, done, d, b_out, zero, ovf);
`else
    modport master (output start, a, b, b_in, input busy, done, d, b_out, zero);
    modport slave  (input start, a, b, b_in, output busy, done, d, b_out, zero);
`endif

endinterface

// File: rtl/sub_digit.sv
// sub_digit: combinational ripple of DIGIT full-subtract cells.
module sub_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             bw_in,
    output logic [DIGIT-1:0] diff,
    output logic             bw_out,
    output logic             bw_msb_in
);

    logic [DIGIT:0] bw;

    always_comb begin
        diff  = '0;
        bw    = '0;
        bw[0] = bw_in;
        for (int i = 0; i < DIGIT; i++) begin
            diff[i]   = a[i] ^ b[i] ^ bw[i];
            bw[i + 1] = (~(a[i] ^ b[i]) & bw[i]) | (~a[i] & b[i]);
        end
    end

    assign bw_out    = bw[DIGIT];
    assign bw_msb_in = bw[DIGIT-1];

endmodule

// File: rtl/serial_sub.sv
// serial_sub: multi-cycle a - b - b_in, DIGIT bits per clock, LSB digit first.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input logic         clk,
    input logic         rst,
    serial_sub_if.slave bus
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = clog2(N);

    if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
        $error("serial_sub: WIDTH must be a multiple of DIGIT with 1 <= DIGIT <= WIDTH");
    end

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, d_q, d_d;
    logic             bw_q, bw_d, b_out_q, b_out_d, zero_q, zero_d;
    logic             busy_q, done_q, done_d;
    logic [DIGIT-1:0] diff;
    logic             dig_bw, dig_msb;
    logic             last;
    logic [WIDTH+DIGIT-1:0] acc_next;

    sub_digit #(.DIGIT(DIGIT)) u_digit (
        .a        (a_q[DIGIT-1:0]),
        .b        (b_q[DIGIT-1:0]),
        .bw_in    (bw_q),
        .diff     (diff),
        .bw_out   (dig_bw),
        .bw_msb_in(dig_msb)
    );

    // New digits enter at the top so the LSB digit ends at bit 0 after N steps.
    assign acc_next = {diff, acc_q};
    assign last     = cnt_q == CW'(N - 1);

`ifdef SERIAL_SUB_OVF_EN
    logic ovf_q, ovf_d;
`else
    logic unused_msb;
    assign unused_msb = dig_msb;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        bw_d    = bw_q;
        acc_d   = acc_q;
        d_d     = d_q;
        b_out_d = b_out_q;
        zero_d  = zero_q;
        done_d  = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = bus.start ? ST_RUN : ST_IDLE;
                if (bus.start) begin
                    a_d   = bus.a;
                    b_d   = bus.b;
                    bw_d  = bus.b_in;
                    cnt_d = '0;
                end
            end
            ST_RUN: begin
                a_d   = a_q >> DIGIT;
                b_d   = b_q >> DIGIT;
                bw_d  = dig_bw;
                acc_d = acc_next[WIDTH+DIGIT-1:DIGIT];
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    state_d = ST_DONE;
                    d_d     = acc_d;
                    b_out_d = dig_bw;
                    zero_d  = acc_d == '0;
                    done_d  = 1'b1;
`ifdef SERIAL_SUB_OVF_EN
                    ovf_d   = dig_msb ^ dig_bw;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            bw_q    <= 1'b0;
            acc_q   <= '0;
            d_q     <= '0;
            b_out_q <= 1'b0;
            zero_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            bw_q    <= bw_d;
            acc_q   <= acc_d;
            d_q     <= d_d;
            b_out_q <= b_out_d;
            zero_q  <= zero_d;
            busy_q  <= state_d == ST_RUN;
            done_q  <= done_d;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.d     = d_q;
    assign bus.b_out = b_out_q;
    assign bus.zero  = zero_q;
`ifdef SERIAL_SUB_OVF_EN
    assign bus.ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: directed and swept checks of serial_sub (DIGIT = 1, 4, 16 over WIDTH = 16).
module tb_serial_sub;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    serial_sub_if #(.WIDTH(16)) m ();
    serial_sub_if #(.WIDTH(16)) s1 ();
    serial_sub_if #(.WIDTH(16)) s4 ();
    serial_sub_if #(.WIDTH(16)) s16 ();

    serial_sub #(.WIDTH(16), .DIGIT(4))  dut (.clk(clk), .rst(rst), .bus(m.slave));
    serial_sub #(.WIDTH(16), .DIGIT(1))  u1  (.clk(clk), .rst(rst), .bus(s1.slave));
    serial_sub #(.WIDTH(16), .DIGIT(4))  u4  (.clk(clk), .rst(rst), .bus(s4.slave));
    serial_sub #(.WIDTH(16), .DIGIT(16)) u16 (.clk(clk), .rst(rst), .bus(s16.slave));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic op4(input logic [15:0] a, input logic [15:0] b, input logic bin,
                       input logic [15:0] ed, input logic ebo, input logic ez,
                       input logic eovf, input string tag);
        int         cyc;
        int         bc;
        logic [15:0] pd;
        logic       held;
        pd   = m.d;
        held = 1'b1;
        m.start = 1'b1; m.a = a; m.b = b; m.b_in = bin;
        tick;
        m.start = 1'b0; m.a = ~a; m.b = ~b; m.b_in = ~bin;
        cyc = 0;
        bc  = 0;
        while (!m.done && cyc < 20) begin
            bc += int'(m.busy);
            held &= (m.d === pd);
            tick;
            cyc++;
        end
        chk({tag, " latency"}, cyc, 4);
        chk({tag, " busy cycles"}, bc, 4);
        chk({tag, " d held"}, held, 1);
        chk({tag, " d"}, m.d, ed);
        chk({tag, " b_out"}, m.b_out, ebo);
        chk({tag, " zero"}, m.zero, ez);
        chk({tag, " busy at done"}, m.busy, 0);
`ifdef SERIAL_SUB_OVF_EN
        chk({tag, " ovf"}, m.ovf, eovf);
`else
        if (eovf === 1'bx) $display("unexpected ovf reference");
`endif
        tick;
        chk({tag, " done pulse"}, m.done, 0);
    endtask

    initial begin
        int          cyc;
        logic        seen;
        logic [15:0] ra, rb;
        logic        rbi;
        logic [16:0] ex;
        int          l1, l4, l16;
        logic [15:0] d1, d4, d16;
        logic        bo1, bo4, bo16;

        m.start = 0;   m.a = 0;   m.b = 0;   m.b_in = 0;
        s1.start = 0;  s1.a = 0;  s1.b = 0;  s1.b_in = 0;
        s4.start = 0;  s4.a = 0;  s4.b = 0;  s4.b_in = 0;
        s16.start = 0; s16.a = 0; s16.b = 0; s16.b_in = 0;
        rst = 1'b1;
        tick;
        tick;
        chk("reset busy", m.busy, 0);
        chk("reset done", m.done, 0);
        chk("reset d", m.d, 0);
        chk("reset b_out", m.b_out, 0);
        chk("reset zero", m.zero, 0);
`ifdef SERIAL_SUB_OVF_EN
        chk("reset ovf", m.ovf, 0);
`endif
        rst = 1'b0;
        tick;

        op4(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, "normal");
        op4(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0, "wrap");
        op4(16'h0005, 16'h0004, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, "zero");

        // Start held through the DONE cycle launches the next op with no gap.
        m.start = 1'b1; m.a = 16'h1111; m.b = 16'h0011; m.b_in = 1'b0;
        tick;
        m.start = 1'b0;
        cyc = 0;
        while (!m.done && cyc < 20) begin tick; cyc++; end
        chk("b2b first latency", cyc, 4);
        chk("b2b first d", m.d, 16'h1100);
        m.start = 1'b1; m.a = 16'h00FF; m.b = 16'h000F;
        tick;
        chk("b2b no-gap busy", m.busy, 1);
        chk("b2b no-gap done", m.done, 0);
        m.start = 1'b0;
        cyc = 0;
        while (!m.done && cyc < 20) begin tick; cyc++; end
        chk("b2b second latency", cyc, 4);
        chk("b2b second d", m.d, 16'h00F0);
        tick;

        // A start pulse mid-RUN must not disturb the latched operands.
        m.start = 1'b1; m.a = 16'h0100; m.b = 16'h0001; m.b_in = 1'b0;
        tick;
        m.start = 1'b0;
        tick;
        m.start = 1'b1; m.a = 16'hFFFF; m.b = 16'h0000;
        tick;
        m.start = 1'b0;
        cyc = 2;
        while (!m.done && cyc < 20) begin tick; cyc++; end
        chk("midrun latency", cyc, 4);
        chk("midrun d", m.d, 16'h00FF);
        chk("midrun b_out", m.b_out, 0);
        tick;

        // Reset in the second RUN cycle aborts with no done.
        m.start = 1'b1; m.a = 16'h9999; m.b = 16'h1111; m.b_in = 1'b0;
        tick;
        m.start = 1'b0;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("abort busy", m.busy, 0);
        chk("abort done", m.done, 0);
        chk("abort d", m.d, 0);
        chk("abort zero", m.zero, 0);
        chk("abort b_out", m.b_out, 0);
        seen = 1'b0;
        repeat (8) begin tick; seen |= m.done; end
        chk("abort no done", seen, 0);
        op4(16'h4321, 16'h1234, 1'b0, 16'h30ED, 1'b0, 1'b0, 1'b0, "after abort");

`ifdef SERIAL_SUB_OVF_EN
        op4(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b1, "ovf neg-pos");
        op4(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1, "ovf pos-neg");
        op4(16'h0003, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, "ovf none");
`endif

        for (int v = 0; v < 1000; v++) begin
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            rbi = 1'($urandom_range(0, 1));
            ex  = {1'b0, ra} - {1'b0, rb} - {16'd0, rbi};
            s1.start = 1'b1;  s1.a = ra;  s1.b = rb;  s1.b_in = rbi;
            s4.start = 1'b1;  s4.a = ra;  s4.b = rb;  s4.b_in = rbi;
            s16.start = 1'b1; s16.a = ra; s16.b = rb; s16.b_in = rbi;
            tick;
            s1.start = 1'b0; s4.start = 1'b0; s16.start = 1'b0;
            l1 = 0; l4 = 0; l16 = 0;
            d1 = 'x; d4 = 'x; d16 = 'x;
            bo1 = 1'bx; bo4 = 1'bx; bo16 = 1'bx;
            for (int c = 1; c <= 16; c++) begin
                tick;
                if (s1.done && l1 == 0)   begin l1 = c;  d1 = s1.d;   bo1 = s1.b_out;   end
                if (s4.done && l4 == 0)   begin l4 = c;  d4 = s4.d;   bo4 = s4.b_out;   end
                if (s16.done && l16 == 0) begin l16 = c; d16 = s16.d; bo16 = s16.b_out; end
            end
            chk("sweep D1 latency", l1, 16);
            chk("sweep D1 d", d1, ex[15:0]);
            chk("sweep D1 b_out", bo1, ex[16]);
            chk("sweep D4 latency", l4, 4);
            chk("sweep D4 d", d4, ex[15:0]);
            chk("sweep D4 b_out", bo4, ex[16]);
            chk("sweep D16 latency", l16, 1);
            chk("sweep D16 d", d16, ex[15:0]);
            chk("sweep D16 b_out", bo16, ex[16]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
